// File: rtl/branch_target_loader.sv
// branch_target_loader
// Runtime-loadable branch-target table for the fetch path. Targets arrive
// over a valid/ready write port and fill consecutive entries from index 0.
// The addr -> Target lookup stays combinational and returns 0 for entries
// that have not been loaded since the last accepted Start.
//
// Handshake: a write beat transfers on a rising Clk edge where
// Wr_valid && Wr_ready are both high and Start is low. Wr_ready is high in
// every LOAD cycle. A Start in the same cycle takes priority and the
// offered beat is dropped. Wr_data must be stable whenever Wr_valid is high.
module branch_target_loader #(
  parameter int DEPTH = 32,
  parameter int TW    = 10
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic [$clog2(DEPTH):0]   Count,
  input  logic                     Wr_valid,
  input  logic [TW-1:0]            Wr_data,
  output logic                     Wr_ready,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(DEPTH):0]   Loaded,
  output logic                     Err,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [TW-1:0]            Target,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_loaded;
  logic          r_err;
  logic [TW-1:0] r_table [DEPTH];

  logic          w_start_ok;
  logic          w_start_bad;
  logic          w_beat;
  logic [CW-1:0] w_loaded_inc;
  logic [CW-1:0] w_addr_ext;
  logic          w_hit;
  logic          w_done_miss;
  logic          w_wr_ready;
  logic          w_busy;
  logic          w_done;

  // A legal Count is 1..DEPTH; anything else only raises Err.
  assign w_start_ok   = Start && (Count != '0) && (Count <= CW'(DEPTH));
  assign w_start_bad  = Start && !w_start_ok;
  // Start always wins over a beat offered in the same cycle.
  assign w_beat       = (r_state == S_LOAD) && Wr_valid && !Start;
  assign w_loaded_inc = r_loaded + CW'(1);
  // Zero-extend addr so the bound check against Loaded is done at full width.
  assign w_addr_ext   = {1'b0, addr};
  assign w_hit        = (w_addr_ext < r_loaded);
  assign w_done_miss  = (r_state == S_DONE) && !w_hit;

  // State register; reset forces IDLE without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state handshake/status outputs.
  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_LOAD: begin
        w_wr_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_beat && (w_loaded_inc == r_count)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A legal Start restarts the load from any state, including mid-LOAD.
    if (w_start_ok) begin
      w_state_next = S_LOAD;
    end
  end

  // Count latch, fill pointer and table storage; a legal Start wipes the table.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count  <= '0;
      r_loaded <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_start_ok) begin
      r_count  <= Count;
      r_loaded <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_beat) begin
      // Loaded never passes r_count because the final beat leaves LOAD.
      r_table[r_loaded[AW-1:0]] <= Wr_data;
      r_loaded                  <= w_loaded_inc;
    end
  end

  // Sticky error: illegal Count, or an out-of-range lookup while in DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_start_bad || w_done_miss) begin
      r_err <= 1'b1;
    end
  end

  // Lookup: entries beyond the loaded region read as 0.
  always_comb begin
    Target = '0;
    if (w_hit) begin
      Target = r_table[addr];
    end
  end

  assign Wr_ready  = w_wr_ready;
  assign Busy      = w_busy;
  assign Done      = w_done;
  assign Loaded    = r_loaded;
  assign Err       = r_err;
  assign dbg_state = r_state;

endmodule
